fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmitter that drains the 4-bit synchronous FIFO and sends each popped word as an asynchronous UART-style frame on a single output line. It sits directly downstream of the FIFO's read port and supplies its `read` strobe, consuming its registered `data_out`. Each frame has one start bit, WIDTH data bits sent LSB first, an optional even-parity bit and one stop bit. The bit period is a fixed number of clock cycles.

## Interface
- `WIDTH`, default 4: data bits per frame; must match the FIFO word width.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be at least 2.
- `PARITY_EN`, default 0: when 1, an even-parity bit is inserted after the data bits.

- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `fifo_empty`  in  1: level flag, high when the FIFO holds no words.
- `fifo_data`  in  WIDTH: FIFO registered read data, valid in the cycle after `fifo_rd`.
- `fifo_rd`  out  1: one-cycle pop strobe to the FIFO.
- `tx`  out  1: serial line, idles high.
- `busy`  out  1: high whenever a fetch or frame is in progress.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If `fifo_empty`=0, go to FETCH; otherwise stay in IDLE.
- FETCH: `fifo_rd`=1 for exactly this cycle. Always go to LOAD.
- LOAD: capture `fifo_data` into the shift register, clear the baud counter and bit index, then go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx`=shift[0]. At each bit end, shift right and increment the bit index. After WIDTH bits, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: `tx` = XOR of the captured word, so the total count of ones is even. Lasts CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- `busy` = (state != IDLE). `fifo_rd` = (state == FETCH), decoded from the registered state with no combinational path from inputs.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0. The bit-end tick fires when count == CLKS_PER_BIT-1.
- Bit index: width $clog2(WIDTH+1), so it has no overflow at WIDTH.
- `fifo_empty` is sampled only in IDLE. Changes at any other time are ignored.
- At most one pop per frame; no prefetch is done.

## Timing
- Reset values: `tx`=1, `fifo_rd`=0, `busy`=0, state=IDLE, all counters 0, shift register 0.
- Reset mid-frame: on the cycle after `rst` is sampled high, `tx`=1 and the frame is aborted. A word already popped is lost. `fifo_rd` is never asserted while `rst`=1.
- Latency: if IDLE samples `fifo_empty`=0 in cycle N, then `fifo_rd`=1 in N+1, capture happens in N+2, and `tx` falls at N+3.
- Frame length from START entry: (2 + WIDTH + PARITY_EN) * CLKS_PER_BIT cycles.
- Back-to-back frames: at least 3 cycles of `tx`=1 (IDLE, FETCH, LOAD) follow the last STOP cycle before the next start bit.
- Empty FIFO: the block stays in IDLE indefinitely and never asserts `fifo_rd`, so it never underflows.

## Structure
- Package `fifo_uart_pkg`: state enum `tx_state_t` and the default constants for WIDTH, CLKS_PER_BIT and PARITY_EN.
- Sub-module `baud_gen`: a parameterised counter with a synchronous clear and a `tick` output. It is instantiated once and cleared in LOAD.
- Top level contains the FSM, shift register, bit index and parity XOR.

## Test plan
All scenarios use WIDTH=4, CLKS_PER_BIT=4.
- Reset: hold `rst` for 3 cycles with `fifo_empty`=0. Required: `tx`=1, `fifo_rd`=0 and `busy`=0 throughout; the first `fifo_rd` appears 1 cycle after `rst` falls.
- Single word 4'hA, PARITY_EN=0. Required: exactly one `fifo_rd` pulse; `tx` sequence 0,0,1,0,1,1, each bit held 4 cycles (24 cycles total); `busy` falls after the stop bit.
- Word 4'hB, PARITY_EN=1. Required: `tx` sequence 0,1,1,0,1,1(parity),1(stop), 28 cycles total.
- Two words 4'h3 then 4'hC, with `fifo_empty` low throughout. Required: exactly two `fifo_rd` pulses, separated by 24+3 cycles; the second start bit comes exactly 3 cycles after the first stop bit ends.
- `fifo_empty` held high for 100 cycles. Required: no `fifo_rd` pulse, `tx`=1 throughout. Then toggle `fifo_empty` during an active frame. Required: the frame is unaffected and no extra pop occurs.
- Assert `rst` in the 2nd data bit of word 4'h5. Required: `tx`=1 on the next cycle, state is IDLE, and the next frame starts cleanly with a new pop.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared FSM state encoding and default parameters for fifo_uart_tx
package fifo_uart_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} tx_state_t;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam bit DEF_PARITY_EN = 1'b0;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read-port handshake between the FIFO and its serial drain
//   fifo_empty : FIFO -> tx, level flag, high when no words are held
//   fifo_data  : FIFO -> tx, registered read data, valid the cycle after fifo_rd
//   fifo_rd    : tx -> FIFO, one-cycle pop strobe
interface fifo_uart_tx_if
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd;
    modport master (input fifo_empty, input fifo_data, output fifo_rd);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd);
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// baud_gen: free-running bit-period counter with synchronous clear and bit-end tick
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the period at count 0
//   tick     : high in the last cycle of each bit period
module baud_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    logic [CW-1:0] cnt;
    assign tick = (cnt == LAST);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else cnt <= tick ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops one FIFO word at a time and sends it as a start/data/parity/stop frame
//   clk, rst : clock, synchronous active-high reset
//   fif      : FIFO read port (master side: drives fifo_rd, consumes fifo_empty/fifo_data)
//   tx       : serial line, idles high
//   busy     : high while a fetch or frame is in progress
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit PARITY_EN    = DEF_PARITY_EN
) (
    input  logic            clk,
    input  logic            rst,
    fifo_uart_tx_if.master  fif,
    output logic            tx,
    output logic            busy
);
    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);
    tx_state_t        state;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_nxt;
    logic [IW-1:0]    bit_idx;
    logic             par;
    logic             tick;
    logic             rd;
    assign shift_nxt   = shift >> 1;
    assign fif.fifo_rd = rd;
    baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == LOAD),
        .tick (tick)
    );
    // tx, rd and busy are registered alongside the state so each one reflects
    // the state being entered rather than being decoded after the fact
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            rd      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            rd <= 1'b0;
            unique case (state)
                IDLE: if (!fif.fifo_empty) begin
                    state <= FETCH;
                    rd    <= 1'b1;
                    busy  <= 1'b1;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shift   <= fif.fifo_data;
                    par     <= ^fif.fifo_data;
                    bit_idx <= '0;
                    tx      <= 1'b0;
                    state   <= START;
                end
                START: if (tick) begin
                    tx    <= shift[0];
                    state <= DATA;
                end
                DATA: if (tick) begin
                    shift   <= shift_nxt;
                    bit_idx <= bit_idx + IW'(1);
                    if (bit_idx == LAST_BIT) begin
                        state <= PARITY_EN ? PARITY : STOP;
                        tx    <= PARITY_EN ? par : 1'b1;
                    end else begin
                        tx <= shift_nxt[0];
                    end
                end
                PARITY: if (tick) begin
                    tx    <= 1'b1;
                    state <= STOP;
                end
                STOP: if (tick) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench; dut 0 without parity, dut 1 with even parity
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_w [2];
    logic       rd_w [2];
    logic       busy_w [2];
    logic [3:0] fdata [2] = '{4'h0, 4'h0};
    logic       hold_empty [2] = '{1'b0, 1'b0};
    logic       force_ne [2] = '{1'b0, 1'b0};
    logic [3:0] fmem [2][64];
    logic [3:0] emem [2][64];
    int wp [2] = '{0, 0};
    int rp [2] = '{0, 0};
    int pops [2] = '{0, 0};
    int ewp [2] = '{0, 0};
    int erp [2] = '{0, 0};
    int nf [2] = '{0, 0};
    int pcyc [2][16];
    int st [2][16];
    int en [2][16];
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fifo_uart_tx_if #(.WIDTH(4)) fif ();
        assign fif.fifo_empty = !force_ne[g] && (hold_empty[g] || wp[g] == rp[g]);
        assign fif.fifo_data  = fdata[g];
        assign rd_w[g]        = fif.fifo_rd;
        fifo_uart_tx #(.WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(g == 1)) dut (
            .clk  (clk),
            .rst  (rst),
            .fif  (fif),
            .tx   (tx_w[g]),
            .busy (busy_w[g])
        );
    end

    // FIFO model: registered read data one cycle after the pop strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rd_w[d] === 1'b1) begin
                if (pops[d] < 16) pcyc[d][pops[d]] <= cyc;
                pops[d] <= pops[d] + 1;
                if (rp[d] != wp[d]) begin
                    fdata[d] <= fmem[d][rp[d] % 64];
                    rp[d]    <= rp[d] + 1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input logic [3:0] w);
        fmem[d][wp[d] % 64]  = w;
        emem[d][ewp[d] % 64] = w;
        wp[d]++;
        ewp[d]++;
    endtask

    // Receiver: samples every cycle of a frame, requires each bit to hold for CPB
    // cycles, then pops the scoreboard and compares the recovered word
    task automatic rx(input int g);
        int         nb = 6 + g;
        int         s;
        logic [7:0] bits = '0;
        logic       stable = 1'b1;
        logic       ab = 1'b0;
        logic [3:0] w;
        @(negedge clk);
        if (rst || tx_w[g] !== 1'b0) return;
        s = cyc;
        for (int i = 0; i < nb * CPB && !ab; i++) begin
            if (i > 0) @(negedge clk);
            if (rst) ab = 1'b1;
            else if (i % CPB == 0) bits[i / CPB] = tx_w[g];
            else if (tx_w[g] !== bits[i / CPB]) stable = 1'b0;
        end
        if (ab) begin
            if (erp[g] < ewp[g]) erp[g]++;
            while (rst) @(negedge clk);
            return;
        end
        check($sformatf("start_bit_d%0d", g), bits[0], 1'b0);
        check($sformatf("bit_hold_d%0d", g), stable, 1'b1);
        check($sformatf("frame_expected_d%0d", g), erp[g] < ewp[g], 1'b1);
        w = emem[g][erp[g] % 64];
        erp[g]++;
        check($sformatf("word_d%0d", g), bits[4:1], w);
        if (g == 1) check("parity_bit", bits[5], ^w);
        check($sformatf("stop_bit_d%0d", g), bits[nb-1], 1'b1);
        if (nf[g] < 16) begin
            st[g][nf[g]] = s;
            en[g][nf[g]] = cyc;
        end
        nf[g]++;
        @(negedge clk);
        check($sformatf("busy_after_stop_d%0d", g), {busy_w[g], tx_w[g]}, 2'b01);
    endtask

    initial forever rx(0);
    initial forever rx(1);

    task automatic wait_frames(input int d, input int n);
        int t = 0;
        while (nf[d] < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("frame_timeout", nf[d] >= n, 1'b1);
    endtask

    task automatic wait_rd(input int d);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (rd_w[d] !== 1'b1 && t < 200);
        check("rd_timeout", rd_w[d], 1'b1);
    endtask

    initial begin
        int p, n, bad;
        push(0, 4'h6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs_d0", {tx_w[0], rd_w[0], busy_w[0]}, 3'b100);
            check("reset_outputs_d1", {tx_w[1], rd_w[1], busy_w[1]}, 3'b100);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        check("first_rd_after_rst", rd_w[0], 1'b1);
        wait_frames(0, 1);
        repeat (3) @(negedge clk);

        p = pops[0];
        push(0, 4'hA);
        wait_frames(0, 2);
        repeat (5) @(negedge clk);
        check("pops_single", pops[0] - p, 1);

        push(1, 4'hB);
        wait_frames(1, 1);
        repeat (5) @(negedge clk);
        check("pops_parity", pops[1], 1);

        p = pops[0];
        n = nf[0];
        push(0, 4'h3);
        push(0, 4'hC);
        wait_frames(0, n + 2);
        repeat (5) @(negedge clk);
        check("pops_pair", pops[0] - p, 2);
        check("pop_spacing", pcyc[0][p+1] - pcyc[0][p], 27);
        check("interframe_gap", st[0][n+1] - en[0][n] - 1, 3);

        hold_empty[0] = 1'b1;
        push(0, 4'h7);
        p = pops[0];
        n = nf[0];
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_w[0] !== 1'b0 || tx_w[0] !== 1'b1) bad++;
        end
        check("empty_hold_quiet", bad, 0);
        #1 hold_empty[0] = 1'b0;
        wait_rd(0);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1 force_ne[0] = ~force_ne[0];
            @(negedge clk);
        end
        wait_frames(0, n + 1);
        repeat (10) @(negedge clk);
        check("pops_toggle", pops[0] - p, 1);

        p = pops[0];
        n = nf[0];
        push(0, 4'h5);
        wait_rd(0);
        repeat (10) @(negedge clk);
        check("data_bit1_before_rst", tx_w[0], 1'b0);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_abort_outputs", {tx_w[0], rd_w[0], busy_w[0]}, 3'b100);
        #1 rst = 1'b0;
        push(0, 4'h9);
        wait_frames(0, n + 1);
        repeat (5) @(negedge clk);
        check("pops_after_rst", pops[0] - p, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end
endmodule
